// File: rtl/rv_iommu_pkg.sv
// Shared types and constants for the IOMMU MRIF engine: AXI channel
// structs, the engine state encoding, the queue entry layout and the fault cause.
package rv_iommu;

   localparam int unsigned CAUSE_LEN = 12;
   localparam logic [CAUSE_LEN-1:0] MSI_PT_DATA_CORRUPTION = 12'd270;

   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   // AtomicStore, little-endian, SET operation
   localparam logic [5:0] AXI_ATOP_SET_LE = 6'b01_0_011;

   typedef enum logic [3:0] {
      IDLE, RD_AR, RD_R, WR_AW, WR_W, WR_B, NT_AW, NT_W, NT_B, DRAIN
   } mrif_state_e;

   // Width of an interrupt identity for a given MRIF size
   function automatic int unsigned mrif_id_w(input int unsigned num_ids);
      return $clog2(num_ids);
   endfunction

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [5:0]  atop;
   } axi_aw_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } axi_ar_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } axi_w_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } axi_b_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } axi_r_t;

   typedef struct packed {
      axi_aw_t aw;
      logic    aw_valid;
      axi_w_t  w;
      logic    w_valid;
      logic    b_ready;
      axi_ar_t ar;
      logic    ar_valid;
      logic    r_ready;
   } axi_full_req_t;

   typedef struct packed {
      logic   aw_ready;
      logic   ar_ready;
      logic   w_ready;
      logic   b_valid;
      axi_b_t b;
      logic   r_valid;
      axi_r_t r;
   } axi_full_rsp_t;

   // One queued request; ign marks an identity outside the MRIF
   typedef struct packed {
      logic        ign;
      logic [10:0] id;
      logic [46:0] mrif;
      logic [10:0] nid;
      logic [43:0] ppn;
   } mrif_entry_t;

endpackage

// File: rtl/rv_iommu_mrif_fifo.sv
// Request queue for the MRIF engine: power-of-two depth, wrap-bit pointers.
module rv_iommu_mrif_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W:0]   wr_ptr_q;
   logic [PTR_W:0]   rd_ptr_q;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

   // Pointer update; a push into a full queue or a pop from an empty one is dropped
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Entry storage, written on an accepted push
   always_ff @(posedge clk_i) begin
      if (push_i && !full_o) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
   end

endmodule

// File: rtl/rv_iommu_mrif_engine.sv
// MRIF engine: sets the interrupt-pending bit for an MSI in a memory-resident
// interrupt file and, when the identity is enabled, writes the notice MSI.
module rv_iommu_mrif_engine import rv_iommu::*; #(
   parameter type         axi_req_t   = logic,
   parameter type         axi_rsp_t   = logic,
   parameter int unsigned NUM_IDS     = 2048,
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter bit          ATOMIC_EN   = 1'b0
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           req_valid_i,
   output logic                           req_ready_o,
   input  logic [31:0]                    int_id_i,
   input  logic [46:0]                    mrif_addr_i,
   input  logic [10:0]                    notice_nid_i,
   input  logic [43:0]                    notice_ppn_i,
   output axi_req_t                       mem_req_o,
   input  axi_rsp_t                       mem_resp_i,
   output logic                           done_o,
   output logic                           ignore_o,
   output logic                           error_o,
   output logic [rv_iommu::CAUSE_LEN-1:0] cause_o
);

   localparam int unsigned MRIF_ID_W = mrif_id_w(NUM_IDS);
   localparam int unsigned ENTRY_W   = $bits(mrif_entry_t);

   mrif_state_e   state_q, state_d;
   axi_full_req_t req_s;
   axi_full_rsp_t rsp_s;
   mrif_entry_t   push_entry, head;
   logic          fifo_full, fifo_empty, fifo_pop;
   logic          load, ip_ld, ie_ld, ie_bit, ip_hit;
   logic [55:0]   pptr_q;
   logic [5:0]    id_q;
   logic [10:0]   nid_q;
   logic [43:0]   ppn_q;
   logic [63:0]   ip_q;
   logic          ie_q;
   logic          unused_rsp_ids;

   assign rsp_s          = axi_full_rsp_t'(mem_resp_i);
   assign mem_req_o      = axi_req_t'(req_s);
   assign unused_rsp_ids = ^{rsp_s.b.id, rsp_s.r.id};

   assign req_ready_o = !fifo_full && !rst_i;
   assign push_entry  = '{ign:  |int_id_i[31:MRIF_ID_W],
                          id:   int_id_i[10:0],
                          mrif: mrif_addr_i,
                          nid:  notice_nid_i,
                          ppn:  notice_ppn_i};

   rv_iommu_mrif_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (req_valid_i && req_ready_o),
      .data_i  (push_entry),
      .pop_i   (fifo_pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // In atomic mode the set has already landed, so IP counts as set
   assign ie_bit  = rsp_s.r.data[id_q];
   assign ip_hit  = ATOMIC_EN ? 1'b1 : ip_q[id_q];
   assign cause_o = error_o ? MSI_PT_DATA_CORRUPTION : '0;

   // State register; reset abandons any in-flight transaction
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Request context and IP/IE captures
   always_ff @(posedge clk_i) begin
      if (load) begin
         pptr_q <= {head.mrif, head.id[10:6], 4'b0};
         id_q   <= head.id[5:0];
         nid_q  <= head.nid;
         ppn_q  <= head.ppn;
      end
      if (ip_ld) ip_q <= rsp_s.r.data;
      if (ie_ld) ie_q <= ie_bit;
   end

   // Next-state, AXI channel drive and status pulses
   always_comb begin
      state_d  = state_q;
      req_s    = '0;
      fifo_pop = 1'b0;
      load     = 1'b0;
      ip_ld    = 1'b0;
      ie_ld    = 1'b0;
      done_o   = 1'b0;
      ignore_o = 1'b0;
      error_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               if (head.ign) begin
                  ignore_o = 1'b1;
               end else begin
                  load    = 1'b1;
                  state_d = ATOMIC_EN ? WR_AW : RD_AR;
               end
            end
         end
         RD_AR: begin
            req_s.ar_valid = 1'b1;
            req_s.ar.id    = 4'b0100;
            req_s.ar.size  = 3'b011;
            req_s.ar.burst = AXI_BURST_INCR;
            // Atomic mode reads only the IE word at pptr+8
            req_s.ar.addr  = ATOMIC_EN ? {8'b0, pptr_q[55:4], 4'h8} : {8'b0, pptr_q};
            req_s.ar.len   = ATOMIC_EN ? 8'd0 : 8'd1;
            if (rsp_s.ar_ready) state_d = RD_R;
         end
         RD_R: begin
            req_s.r_ready = 1'b1;
            if (rsp_s.r_valid) begin
               if (rsp_s.r.resp != AXI_RESP_OKAY) begin
                  if (rsp_s.r.last) begin
                     error_o = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = DRAIN;
                  end
               end else if (!rsp_s.r.last) begin
                  ip_ld = 1'b1;
               end else begin
                  ie_ld = 1'b1;
                  if (!ip_hit) begin
                     state_d = WR_AW;
                  end else if (ie_bit) begin
                     state_d = NT_AW;
                  end else begin
                     done_o  = 1'b1;
                     state_d = IDLE;
                  end
               end
            end
         end
         WR_AW: begin
            req_s.aw_valid = 1'b1;
            req_s.aw.id    = 4'b0100;
            req_s.aw.addr  = {8'b0, pptr_q};
            req_s.aw.len   = 8'd0;
            req_s.aw.size  = 3'b011;
            req_s.aw.burst = AXI_BURST_INCR;
            req_s.aw.atop  = ATOMIC_EN ? AXI_ATOP_SET_LE : 6'b0;
            if (rsp_s.aw_ready) state_d = WR_W;
         end
         WR_W: begin
            req_s.w_valid = 1'b1;
            req_s.w.data  = ATOMIC_EN ? (64'd1 << id_q) : (ip_q | (64'd1 << id_q));
            req_s.w.strb  = 8'hFF;
            req_s.w.last  = 1'b1;
            if (rsp_s.w_ready) state_d = WR_B;
         end
         WR_B: begin
            req_s.b_ready = 1'b1;
            if (rsp_s.b_valid) begin
               if (rsp_s.b.resp != AXI_RESP_OKAY) begin
                  error_o = 1'b1;
                  state_d = IDLE;
               end else if (ATOMIC_EN) begin
                  state_d = RD_AR;
               end else if (ie_q) begin
                  state_d = NT_AW;
               end else begin
                  done_o  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         NT_AW: begin
            req_s.aw_valid = 1'b1;
            req_s.aw.id    = 4'b0011;
            req_s.aw.addr  = {8'b0, ppn_q, 12'b0};
            req_s.aw.len   = 8'd0;
            req_s.aw.size  = 3'b010;
            req_s.aw.burst = AXI_BURST_INCR;
            if (rsp_s.aw_ready) state_d = NT_W;
         end
         NT_W: begin
            req_s.w_valid = 1'b1;
            req_s.w.data  = {32'b0, 21'b0, nid_q};
            req_s.w.strb  = 8'h0F;
            req_s.w.last  = 1'b1;
            if (rsp_s.w_ready) state_d = NT_B;
         end
         NT_B: begin
            req_s.b_ready = 1'b1;
            if (rsp_s.b_valid) begin
               if (rsp_s.b.resp != AXI_RESP_OKAY) error_o = 1'b1;
               else                                done_o  = 1'b1;
               state_d = IDLE;
            end
         end
         DRAIN: begin
            // The fault is reported once the burst has been fully consumed
            req_s.r_ready = 1'b1;
            if (rsp_s.r_valid && rsp_s.r.last) begin
               error_o = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rv_iommu_mrif_engine.sv
// Directed bench for the MRIF engine: one instance per IP update mode, the
// bench plays the AXI slave and checks every request field it is handed.
module tb_rv_iommu_mrif_engine;
   import rv_iommu::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          req_valid [2];
   logic          ready     [2];
   logic          done      [2];
   logic          ign       [2];
   logic          err       [2];
   logic [11:0]   cause     [2];
   axi_full_req_t mreq      [2];
   axi_full_rsp_t mresp     [2];
   logic [31:0]   int_id;
   logic [46:0]   mrif;
   logic [10:0]   nid;
   logic [43:0]   ppn;

   int total = 0;
   int bad   = 0;

   rv_iommu_mrif_engine #(
      .axi_req_t(axi_full_req_t), .axi_rsp_t(axi_full_rsp_t),
      .NUM_IDS(2048), .QUEUE_DEPTH(4), .ATOMIC_EN(1'b0)
   ) u_dut0 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[0]), .req_ready_o(ready[0]),
      .int_id_i(int_id), .mrif_addr_i(mrif), .notice_nid_i(nid), .notice_ppn_i(ppn),
      .mem_req_o(mreq[0]), .mem_resp_i(mresp[0]),
      .done_o(done[0]), .ignore_o(ign[0]), .error_o(err[0]), .cause_o(cause[0])
   );

   rv_iommu_mrif_engine #(
      .axi_req_t(axi_full_req_t), .axi_rsp_t(axi_full_rsp_t),
      .NUM_IDS(2048), .QUEUE_DEPTH(4), .ATOMIC_EN(1'b1)
   ) u_dut1 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[1]), .req_ready_o(ready[1]),
      .int_id_i(int_id), .mrif_addr_i(mrif), .notice_nid_i(nid), .notice_ppn_i(ppn),
      .mem_req_o(mreq[1]), .mem_resp_i(mresp[1]),
      .done_o(done[1]), .ignore_o(ign[1]), .error_o(err[1]), .cause_o(cause[1])
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input int d, input string tag);
      chk({tag, ".mem_req_bits"}, 64'($countones(mreq[d])), 0);
      chk({tag, ".ctrl"}, {ready[d], done[d], ign[d], err[d]}, 0);
      chk({tag, ".cause"}, cause[d], 0);
   endtask

   task automatic push(input int d, input logic [31:0] id, input logic [46:0] ma,
                       input logic [10:0] n, input logic [43:0] p, input string tag);
      @(negedge clk); #1;
      int_id = id; mrif = ma; nid = n; ppn = p; req_valid[d] = 1'b1;
      #1;
      chk({tag, ".req_ready"}, ready[d], 1);
      @(negedge clk); #1;
      req_valid[d] = 1'b0;
   endtask

   task automatic wait_ar(input int d, input logic [63:0] addr, input logic [7:0] len,
                          input string tag);
      int n = 0;
      @(negedge clk); #1;
      while (!mreq[d].ar_valid && n < 50) begin @(negedge clk); #1; n++; end
      chk({tag, ".ar_valid"}, mreq[d].ar_valid, 1);
      chk({tag, ".ar_addr"}, mreq[d].ar.addr, addr);
      chk({tag, ".ar_len"}, mreq[d].ar.len, len);
      chk({tag, ".ar_id_size_burst"}, {mreq[d].ar.id, mreq[d].ar.size, mreq[d].ar.burst},
          {4'b0100, 3'b011, 2'b01});
      mresp[d].ar_ready = 1'b1;
      @(negedge clk); #1;
      mresp[d].ar_ready = 1'b0;
   endtask

   task automatic wait_aw(input int d, input logic [63:0] addr, input logic [3:0] id,
                          input logic [2:0] size, input logic [5:0] atop, input string tag);
      int n = 0;
      @(negedge clk); #1;
      while (!mreq[d].aw_valid && n < 50) begin @(negedge clk); #1; n++; end
      chk({tag, ".aw_valid"}, mreq[d].aw_valid, 1);
      chk({tag, ".aw_addr"}, mreq[d].aw.addr, addr);
      chk({tag, ".aw_id_size"}, {mreq[d].aw.id, mreq[d].aw.size}, {id, size});
      chk({tag, ".aw_len_burst_atop"}, {mreq[d].aw.len, mreq[d].aw.burst, mreq[d].aw.atop},
          {8'd0, 2'b01, atop});
      mresp[d].aw_ready = 1'b1;
      @(negedge clk); #1;
      mresp[d].aw_ready = 1'b0;
   endtask

   task automatic wait_w(input int d, input logic [63:0] data, input logic [7:0] strb,
                         input string tag);
      int n = 0;
      @(negedge clk); #1;
      while (!mreq[d].w_valid && n < 50) begin @(negedge clk); #1; n++; end
      chk({tag, ".w_valid"}, mreq[d].w_valid, 1);
      chk({tag, ".w_data"}, mreq[d].w.data, data);
      chk({tag, ".w_strb_last"}, {mreq[d].w.strb, mreq[d].w.last}, {strb, 1'b1});
      mresp[d].w_ready = 1'b1;
      @(negedge clk); #1;
      mresp[d].w_ready = 1'b0;
   endtask

   task automatic send_b(input int d, input logic [1:0] resp, input logic exp_done,
                         input logic exp_err, input string tag);
      @(negedge clk); #1;
      mresp[d].b_valid = 1'b1; mresp[d].b.resp = resp;
      #1;
      chk({tag, ".b_ready"}, mreq[d].b_ready, 1);
      chk({tag, ".done"}, done[d], exp_done);
      chk({tag, ".error"}, err[d], exp_err);
      @(negedge clk); #1;
      mresp[d].b_valid = 1'b0; mresp[d].b.resp = 2'b00;
   endtask

   task automatic send_r(input int d, input logic [63:0] data, input logic [1:0] resp,
                         input logic last, input logic exp_done, input logic exp_err,
                         input string tag);
      @(negedge clk); #1;
      mresp[d].r_valid = 1'b1; mresp[d].r.data = data;
      mresp[d].r.resp = resp;  mresp[d].r.last = last;
      #1;
      chk({tag, ".r_ready"}, mreq[d].r_ready, 1);
      chk({tag, ".done"}, done[d], exp_done);
      chk({tag, ".error"}, err[d], exp_err);
      chk({tag, ".cause"}, cause[d], exp_err ? 64'd270 : 64'd0);
      @(negedge clk); #1;
      mresp[d].r_valid = 1'b0; mresp[d].r.last = 1'b0; mresp[d].r.resp = 2'b00;
   endtask

   task automatic idle_watch(input int d, input int cycles, input string tag);
      logic seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk); #1;
         seen = seen | mreq[d].ar_valid | mreq[d].aw_valid;
      end
      chk({tag, ".no_axi_req"}, seen, 0);
   endtask

   initial begin
      req_valid[0] = 1'b0; req_valid[1] = 1'b0;
      mresp[0] = '0; mresp[1] = '0;
      int_id = '0; mrif = '0; nid = '0; ppn = '0;

      // Reset state on both instances, then ready rises right after release
      repeat (3) @(negedge clk);
      #1;
      chk_quiet(0, "rst0");
      chk_quiet(1, "rst1");
      @(negedge clk); rst = 1'b0; #1;
      chk("rst_rel.ready0", ready[0], 1);
      chk("rst_rel.ready1", ready[1], 1);

      // id 70: IP clear, IE bit 6 set -> IP write then notice
      push(0, 32'd70, 47'h1000, 11'h155, 44'hABC, "a");
      chk("a.ar_valid_pop_cycle", mreq[0].ar_valid, 0);
      @(negedge clk); #1;
      chk("a.ar_valid_2_cycles", mreq[0].ar_valid, 1);
      wait_ar(0, 64'h20_0010, 8'd1, "a");
      send_r(0, 64'h0, 2'b00, 1'b0, 1'b0, 1'b0, "a.ip");
      send_r(0, 64'h40, 2'b00, 1'b1, 1'b0, 1'b0, "a.ie");
      wait_aw(0, 64'h20_0010, 4'b0100, 3'b011, 6'h00, "a.ipw");
      wait_w(0, 64'h40, 8'hFF, "a.ipw");
      send_b(0, 2'b00, 1'b0, 1'b0, "a.ipw");
      wait_aw(0, 64'hABC000, 4'b0011, 3'b010, 6'h00, "a.nt");
      wait_w(0, 64'h155, 8'h0F, "a.nt");
      send_b(0, 2'b00, 1'b1, 1'b0, "a.nt");

      // Out-of-range identity is ignored without memory traffic
      push(0, 32'd5000, 47'h1000, 11'h1, 44'h1, "ign");
      chk("ign.pulse", ign[0], 1);
      idle_watch(0, 5, "ign");
      chk("ign.ready", ready[0], 1);

      // SLVERR on the IP beat: drain, fault at the last beat, next request served
      push(0, 32'd3, 47'h2000, 11'h1, 44'h1, "c");
      wait_ar(0, 64'h40_0000, 8'd1, "c");
      send_r(0, 64'h0, 2'b10, 1'b0, 1'b0, 1'b0, "c.ip_err");
      send_r(0, 64'h0, 2'b00, 1'b1, 1'b0, 1'b1, "c.drain");
      push(0, 32'd1, 47'h2000, 11'h1, 44'h1, "c2");
      wait_ar(0, 64'h40_0000, 8'd1, "c2");
      send_r(0, 64'h2, 2'b00, 1'b0, 1'b0, 1'b0, "c2.ip");
      send_r(0, 64'h0, 2'b00, 1'b1, 1'b1, 1'b0, "c2.ie");

      // Back-to-back requests with ar_ready low; first is popped, four queue up
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk); #1;
         int_id = 32'(64 * k + 1); mrif = '0; req_valid[0] = 1'b1;
         #1;
         chk($sformatf("q.ready_req%0d", k), ready[0], (k <= 5) ? 64'd1 : 64'd0);
      end
      @(negedge clk); #1;
      chk("q.ready_held_full", ready[0], 0);
      req_valid[0] = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         wait_ar(0, 64'(16 * k), 8'd1, $sformatf("q%0d", k));
         send_r(0, 64'h2, 2'b00, 1'b0, 1'b0, 1'b0, $sformatf("q%0d.ip", k));
         send_r(0, 64'h0, 2'b00, 1'b1, 1'b1, 1'b0, $sformatf("q%0d.ie", k));
      end
      idle_watch(0, 5, "q.drained");

      // Reset while the IP write data is pending, with one more request queued
      push(0, 32'd2, 47'h10, 11'h1, 44'h1, "e");
      wait_ar(0, 64'h2000, 8'd1, "e");
      push(0, 32'd3, 47'h10, 11'h1, 44'h1, "e.queued");
      send_r(0, 64'h0, 2'b00, 1'b0, 1'b0, 1'b0, "e.ip");
      send_r(0, 64'h0, 2'b00, 1'b1, 1'b0, 1'b0, "e.ie");
      wait_aw(0, 64'h2000, 4'b0100, 3'b011, 6'h00, "e");
      @(negedge clk); #1;
      chk("e.in_wr_w", mreq[0].w_valid, 1);
      rst = 1'b1;
      #1;
      chk_quiet(0, "e.rst");
      @(negedge clk); @(negedge clk);
      rst = 1'b0; #1;
      chk("e.rel.ready", ready[0], 1);
      idle_watch(0, 5, "e.fifo_empty");
      push(0, 32'd1, 47'h10, 11'h1, 44'h1, "e2");
      wait_ar(0, 64'h2000, 8'd1, "e2");
      send_r(0, 64'h2, 2'b00, 1'b0, 1'b0, 1'b0, "e2.ip");
      send_r(0, 64'h0, 2'b00, 1'b1, 1'b1, 1'b0, "e2.ie");

      // Atomic mode, id 3, IE clear: atomic set, IE read at +8, done, no notice
      push(1, 32'd3, 47'h3000, 11'h7, 44'h5, "f");
      wait_aw(1, 64'h60_0000, 4'b0100, 3'b011, 6'h13, "f");
      wait_w(1, 64'h8, 8'hFF, "f");
      send_b(1, 2'b00, 1'b0, 1'b0, "f");
      wait_ar(1, 64'h60_0008, 8'd0, "f");
      send_r(1, 64'h0, 2'b00, 1'b1, 1'b1, 1'b0, "f.ie");
      idle_watch(1, 5, "f.no_notice");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
